// File: rtl/alu_cmd_interface.sv
// Command sequencer between a UART byte link and a combinational ALU: collects operand 1, operand 2 and opcode, then transmits the result byte.
// Optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN.
module alu_cmd_interface #(
    parameter int BUS_LEN        = 8,
    parameter int OPCODE_LEN     = 6,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [BUS_LEN-1:0]    i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_tx_done,
    input  logic [BUS_LEN-1:0]    i_alu_result,
    output logic [BUS_LEN-1:0]    o_ope1,
    output logic [BUS_LEN-1:0]    o_ope2,
    output logic [OPCODE_LEN-1:0] o_opcode,
    output logic [BUS_LEN-1:0]    o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_timeout
);

    typedef enum logic [2:0] {
        GET_OPE1,
        GET_OPE2,
        GET_OPCODE,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t                state_q, state_d;
    logic [BUS_LEN-1:0]    ope1_q, ope1_d;
    logic [BUS_LEN-1:0]    ope2_q, ope2_d;
    logic [OPCODE_LEN-1:0] opcode_q, opcode_d;
    logic [BUS_LEN-1:0]    tx_data_q, tx_data_d;

`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    generate
        if (BUS_LEN > OPCODE_LEN) begin : g_opcode_pad
            logic unused_rx_high;
            assign unused_rx_high = ^i_rx_data[BUS_LEN-1:OPCODE_LEN];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        ope1_d    = ope1_q;
        ope2_d    = ope2_q;
        opcode_d  = opcode_q;
        tx_data_d = tx_data_q;

        case (state_q)
            GET_OPE1: begin
                if (i_rx_done) begin
                    ope1_d  = i_rx_data;
                    state_d = GET_OPE2;
                end
            end
            GET_OPE2: begin
                if (i_rx_done) begin
                    ope2_d  = i_rx_data;
                    state_d = GET_OPCODE;
                end
            end
            GET_OPCODE: begin
                if (i_rx_done) begin
                    opcode_d = i_rx_data[OPCODE_LEN-1:0];
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                tx_data_d = i_alu_result;
                state_d   = SEND;
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = GET_OPE1;
                end
            end
            default: begin
                state_d = GET_OPE1;
            end
        endcase

`ifdef CMD_TIMEOUT_EN
        // The counter only survives a cycle that stays in a collect state without a byte.
        cnt_d     = '0;
        timeout_d = 1'b0;
        if ((state_q == GET_OPE2 || state_q == GET_OPCODE) && !i_rx_done) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = GET_OPE1;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= GET_OPE1;
            ope1_q    <= '0;
            ope2_q    <= '0;
            opcode_q  <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ope1_q    <= ope1_d;
            ope2_q    <= ope2_d;
            opcode_q  <= opcode_d;
            tx_data_q <= tx_data_d;
        end
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_ope1     = ope1_q;
    assign o_ope2     = ope2_q;
    assign o_opcode   = opcode_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = (state_q == SEND);
    assign o_busy     = (state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX);

endmodule

// File: tb/tb_alu_cmd_interface.sv
// Directed self-checking bench for alu_cmd_interface with a behavioural ALU on the operand outputs.
// The timeout scenario is exercised when CMD_TIMEOUT_EN is defined (TIMEOUT_CYCLES=16).
module tb_alu_cmd_interface;

    localparam int BUS_LEN    = 8;
    localparam int OPCODE_LEN = 6;

    logic                  clk;
    logic                  rstN;
    logic [BUS_LEN-1:0]    rxData;
    logic                  rxDone;
    logic                  txDone;
    logic [BUS_LEN-1:0]    aluResult;
    logic [BUS_LEN-1:0]    ope1;
    logic [BUS_LEN-1:0]    ope2;
    logic [OPCODE_LEN-1:0] opcode;
    logic [BUS_LEN-1:0]    txData;
    logic                  txStart;
    logic                  busy;
    logic                  timeout;

    int checkCount     = 0;
    int passCount      = 0;
    int txStartCount   = 0;
    int timeoutCount   = 0;

    alu_cmd_interface #(
        .BUS_LEN        (BUS_LEN),
        .OPCODE_LEN     (OPCODE_LEN),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_rx_data    (rxData),
        .i_rx_done    (rxDone),
        .i_tx_done    (txDone),
        .i_alu_result (aluResult),
        .o_ope1       (ope1),
        .o_ope2       (ope2),
        .o_opcode     (opcode),
        .o_tx_data    (txData),
        .o_tx_start   (txStart),
        .o_busy       (busy),
        .o_timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: MIPS-style function codes, unknown codes return zero.
    function automatic logic [BUS_LEN-1:0] aluModel(input logic [BUS_LEN-1:0] a,
                                                    input logic [BUS_LEN-1:0] b,
                                                    input logic [OPCODE_LEN-1:0] op);
        logic signed [BUS_LEN-1:0] sa;
        sa = a;
        case (op)
            6'h20:   aluModel = a + b;
            6'h22:   aluModel = a - b;
            6'h24:   aluModel = a & b;
            6'h25:   aluModel = a | b;
            6'h26:   aluModel = a ^ b;
            6'h27:   aluModel = ~(a | b);
            6'h03:   aluModel = $unsigned(sa >>> b);
            6'h02:   aluModel = a >> b;
            default: aluModel = '0;
        endcase
    endfunction

    assign aluResult = aluModel(ope1, ope2, opcode);

    always @(negedge clk) begin
        if (txStart) txStartCount++;
        if (timeout) timeoutCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [BUS_LEN-1:0] b);
        @(negedge clk);
        rxData = b;
        rxDone = 1'b1;
        @(negedge clk);
        rxDone = 1'b0;
    endtask

    // Sends a full command and leaves the DUT in WAIT_TX.
    task automatic runCommand(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] op, input logic [5:0] expOp, input logic [7:0] expTx);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(op);
        checkOutput({tag, " exec_start"}, 32'(txStart), 32'd0);
        checkOutput({tag, " exec_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput({tag, " send_start"}, 32'(txStart), 32'd1);
        checkOutput({tag, " opcode"}, 32'(opcode), 32'(expOp));
        checkOutput({tag, " tx_data"}, 32'(txData), 32'(expTx));
        @(negedge clk);
        checkOutput({tag, " wait_start"}, 32'(txStart), 32'd0);
        checkOutput({tag, " wait_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic finishTx(input string tag);
        @(negedge clk);
        txDone = 1'b1;
        @(negedge clk);
        txDone = 1'b0;
        checkOutput({tag, " idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rstN   = 1'b0;
        rxData = '0;
        rxDone = 1'b0;
        txDone = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst ope1", 32'(ope1), 32'd0);
        checkOutput("rst ope2", 32'(ope2), 32'd0);
        checkOutput("rst opcode", 32'(opcode), 32'd0);
        checkOutput("rst tx_data", 32'(txData), 32'd0);
        checkOutput("rst start_busy_to", {29'd0, txStart, busy, timeout}, 32'd0);
        rstN = 1'b1;

        runCommand("add", 8'h05, 8'h03, 8'h20, 6'h20, 8'h08);
        finishTx("add");
        runCommand("sra", 8'h80, 8'h02, 8'h03, 6'h03, 8'hE0);
        finishTx("sra");
        runCommand("sub", 8'h03, 8'h05, 8'h22, 6'h22, 8'hFE);

        // Byte arriving while waiting on the transmitter is discarded.
        applyStimulus(8'h11);
        checkOutput("drop ope1", 32'(ope1), 32'h03);
        checkOutput("drop busy", 32'(busy), 32'd1);
        finishTx("drop");

        runCommand("or", 8'h0F, 8'hF0, 8'h25, 6'h25, 8'hFF);

        @(negedge clk);
        rxData = 8'h77;
        rxDone = 1'b1;
        txDone = 1'b1;
        @(negedge clk);
        rxDone = 1'b0;
        txDone = 1'b0;
        checkOutput("same busy", 32'(busy), 32'd0);
        checkOutput("same ope1", 32'(ope1), 32'h0F);

        @(negedge clk);
        txDone = 1'b1;
        @(negedge clk);
        txDone = 1'b0;
        checkOutput("stray txdone busy", 32'(busy), 32'd0);

        runCommand("hibits", 8'h05, 8'h03, 8'hE0, 6'h20, 8'h08);
        finishTx("hibits");
        runCommand("unknown", 8'h05, 8'h03, 8'h3F, 6'h3F, 8'h00);
        finishTx("unknown");

        applyStimulus(8'h01);
        applyStimulus(8'h02);
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("midrst ope1", 32'(ope1), 32'd0);
        checkOutput("midrst ope2", 32'(ope2), 32'd0);
        rstN = 1'b1;
        txStartCount = 0;
        runCommand("and", 8'h0C, 8'h0A, 8'h24, 6'h24, 8'h08);
        finishTx("and");
        checkOutput("and start_count", 32'(txStartCount), 32'd1);

`ifdef CMD_TIMEOUT_EN
        timeoutCount = 0;
        applyStimulus(8'h05);
        repeat (20) @(negedge clk);
        checkOutput("to pulses", 32'(timeoutCount), 32'd1);
        checkOutput("to busy", 32'(busy), 32'd0);
        checkOutput("to ope1_kept", 32'(ope1), 32'h05);
        runCommand("to_add", 8'h04, 8'h04, 8'h20, 6'h20, 8'h08);
        finishTx("to_add");

        // A byte landing in the expiry cycle must be accepted instead.
        timeoutCount = 0;
        applyStimulus(8'h09);
        repeat (14) @(negedge clk);
        applyStimulus(8'h06);
        checkOutput("expiry ope2", 32'(ope2), 32'h06);
        applyStimulus(8'h20);
        repeat (3) @(negedge clk);
        checkOutput("expiry tx_data", 32'(txData), 32'h0F);
        checkOutput("expiry pulses", 32'(timeoutCount), 32'd0);
        finishTx("expiry");
`else
        timeoutCount = 0;
        applyStimulus(8'h05);
        repeat (40) @(negedge clk);
        checkOutput("noto pulses", 32'(timeoutCount), 32'd0);
        applyStimulus(8'h06);
        checkOutput("noto ope2", 32'(ope2), 32'h06);
        applyStimulus(8'h20);
        repeat (3) @(negedge clk);
        checkOutput("noto tx_data", 32'(txData), 32'h0B);
        finishTx("noto");
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
